dpc_seq: RTL and testbench
==========================

# dpc_seq

Frame sequencer for the defective-pixel-correction (DPC) stage. It tracks row and column position of the incoming Bayer pixel stream. It asserts the window-valid strobe that drives `dpc_judge` only when a full 3x3 neighbourhood exists. It shadows the threshold and enable settings at frame start, and reports frame completion and line-length errors. It sits between the sensor-side stream/line buffers and `dpc_judge` in `dpc_core`.

## Interface
Parameters:
- `IMG_W`, 640: active pixels per line (≥3)
- `IMG_H`, 480: active lines per frame (≥3)
- `CW`, 12: counter width; requires IMG_W and IMG_H ≤ 2^CW
- `JUDGE_LAT`, 3: `dpc_judge` latency from window-valid to judged data

Ports:
- `clk` input 1: single clock; all logic on posedge
- `reset` input 1: asynchronous, active-high reset
- `i_dpc_en` input 1: correction enable; sampled at frame start only
- `i_dpc_threshold` input 8: deviation threshold; sampled at frame start only
- `i_pix_valid` input 1: one pixel accepted this cycle
- `i_sof` input 1: first pixel of frame; qualified by `i_pix_valid`
- `i_eol` input 1: last pixel of line; qualified by `i_pix_valid`
- `o_dpc_threshold` output 8: shadowed threshold to `dpc_judge`
- `o_win_valid` output 1: 3x3 window complete; drives `dpc_judge` `i_line_vaild`
- `o_out_valid` output 1: `o_win_valid` delayed JUDGE_LAT cycles; mirrors judge output
- `o_row`, `o_col` output CW: position of the last accepted pixel
- `o_busy` output 1: state ≠ IDLE
- `o_frame_done` output 1: one-cycle pulse after the last judged pixel of the frame
- `o_err_len` output 1: sticky line-length/framing error; cleared by the next valid SOF

## Operation
- States: IDLE, FILL, RUN, DRAIN.
- IDLE: counters held at 0. The transition to FILL happens on `i_pix_valid & i_sof`. That pixel is (0,0).
- On every accepted SOF:
  - shadow `en` and threshold are loaded, and `o_err_len` is cleared;
  - `o_dpc_threshold` = threshold when `en`=1, else 8'hFF. With 8'hFF no pixel exceeds the threshold, so the judge passes data through.
- Column counter: increments per accepted pixel. It resets to 0 on the pixel after an `i_eol` pixel.
- Row counter: increments on each accepted `i_eol`.
- FILL covers rows 0–1. The transition to RUN happens on the `i_eol` of row 1.
- RUN: each accepted pixel with col ≥ 2 sets `o_win_valid` on the next cycle. Window centre is (row−1, col−1). There are (IMG_W−2)·(IMG_H−2) windows per frame.
- RUN → DRAIN on the accepted `i_eol` of row IMG_H−1.
- DRAIN: counts JUDGE_LAT+1 cycles, pulses `o_frame_done` in the last cycle, then returns to IDLE. Pixels arriving in DRAIN or IDLE without SOF are ignored and set `o_err_len`.
- Length errors (each sets `o_err_len`):
  - `i_eol` with col ≠ IMG_W−1;
  - col reaching IMG_W−1 without `i_eol`. In this case the counter forces wrap as if `i_eol` had been seen.
- SOF in FILL/RUN/DRAIN:
  - sets `o_err_len` (the clear from that SOF does not apply, so the flag stays set);
  - restarts at (0,0) in FILL and reloads the shadows;
  - the in-flight `o_out_valid` pipe keeps draining;
  - no `o_frame_done` is issued for the aborted frame.
- Simultaneous `i_sof` and `i_eol` on one pixel: SOF takes priority, and `i_eol` sets `o_err_len`.
- Reset values: state IDLE; `o_win_valid`, `o_out_valid`, `o_busy`, `o_frame_done`, `o_err_len` all 0; `o_row`, `o_col` 0; `o_dpc_threshold` 8'hFF.

## Timing
- `o_win_valid` is registered and has 1-cycle latency from the accepted pixel. This aligns with the window register stage at the judge input.
- `o_out_valid` = `o_win_valid` through a JUDGE_LAT-deep shift register (no reset dependency beyond the reset to 0).
- Shadow registers update in the cycle after the SOF pixel. `o_dpc_threshold` is stable for the whole frame.
- `o_frame_done` asserts JUDGE_LAT+1 cycles after the last pixel, and 1 cycle after the last `o_out_valid`.
- Gaps in `i_pix_valid` are allowed anywhere, with no minimum blanking. Back-to-back frames are allowed: an SOF in the final DRAIN cycle is legal, is not an error, and still produces the `o_frame_done` pulse.

## Structure
- Shared `dpc_pkg` holds:
  - the state encoding constants (IDLE=2'd0, FILL=2'd1, RUN=2'd2, DRAIN=2'd3);
  - the default JUDGE_LAT;
  - the bypass threshold constant 8'hFF.
- One natural sub-module, `dpc_pos_cnt`: the row/column counter with the wrap and length-error logic.
- The FSM, shadow registers and latency pipe stay in `dpc_seq`.

## Test plan
- Nominal frame, IMG_W=8, IMG_H=6, continuous valid, threshold 8'd40, en=1 → 24 `o_win_valid` pulses; `o_dpc_threshold`=40; `o_frame_done` exactly 4 cycles after the last pixel; `o_err_len`=0.
- Same frame with en=0 → `o_dpc_threshold`=8'hFF for the whole frame; window count still 24.
- Random `i_pix_valid` gaps (~50% duty) → same 24 windows, each 1 cycle after a col≥2 pixel of rows 2–5; threshold changes mid-frame are ignored.
- `i_eol` at col 5 on row 3 → `o_err_len`=1 and row advances; a missing `i_eol` at col 7 forces wrap with `o_err_len`=1; the next clean SOF clears the flag.
- SOF at row 4 col 3 → restart in FILL at (0,0), shadows reloaded, `o_err_len`=1, no `o_frame_done` for the aborted frame.
- Assert `reset` mid-RUN → all outputs return to reset values immediately; the next SOF starts a normal frame.

Source files
------------

// File: rtl/dpc_pkg.sv
// dpc_pkg: shared definitions for the defective-pixel-correction stage.
//   dpc_state_t     - sequencer state encoding (IDLE, FILL, RUN, DRAIN)
//   DPC_JUDGE_LAT   - default dpc_judge latency, window-valid to judged data
//   DPC_BYPASS_THR  - threshold that no deviation exceeds, so the judge passes data through
package dpc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } dpc_state_t;

    localparam int         DPC_JUDGE_LAT  = 3;
    localparam logic [7:0] DPC_BYPASS_THR = 8'hFF;

endpackage

// File: rtl/dpc_pos_cnt.sv
// dpc_pos_cnt: row/column tracker for the incoming pixel stream.
// Holds the position of the last accepted pixel and combinationally presents
// the position the pixel on the input would take if it is accepted now.
// A line ends on i_eol or when the column reaches IMG_W-1. A mismatch between
// the two is a length error, and the counter wraps anyway.
//   clk, reset      - clock, asynchronous active-high reset
//   i_clr           - hold the counters at zero (no frame in progress)
//   i_sof           - accepted start-of-frame pixel: it becomes (0,0)
//   i_adv           - accepted in-frame, non-SOF pixel: advance the position
//   i_eol           - end-of-line flag of the pixel on the input
//   o_cur_row/col   - position of the pixel on the input
//   o_line_end      - that pixel closes its line (explicit or forced)
//   o_len_err       - that pixel has a line-length mismatch
//   o_row/o_col     - position of the last accepted pixel
module dpc_pos_cnt #(
    parameter int IMG_W = 640,
    parameter int CW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_sof,
    input  logic          i_adv,
    input  logic          i_eol,
    output logic [CW-1:0] o_cur_row,
    output logic [CW-1:0] o_cur_col,
    output logic          o_line_end,
    output logic          o_len_err,
    output logic [CW-1:0] o_row,
    output logic [CW-1:0] o_col
);

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    // Set when the last accepted pixel closed its line: the next one starts a new row.
    logic          wrap_q, wrap_d;
    logic          at_last;

    always_comb begin
        o_cur_col  = wrap_q ? '0 : col_q + CW'(1);
        o_cur_row  = wrap_q ? row_q + CW'(1) : row_q;
        at_last    = (o_cur_col == LAST_COL);
        o_line_end = i_eol | at_last;
        o_len_err  = i_eol ^ at_last;
    end

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        wrap_d = wrap_q;
        if (i_sof || i_clr) begin
            row_d  = '0;
            col_d  = '0;
            wrap_d = 1'b0;
        end else if (i_adv) begin
            row_d  = o_cur_row;
            col_d  = o_cur_col;
            wrap_d = o_line_end;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q  <= '0;
            col_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            wrap_q <= wrap_d;
        end
    end

    assign o_row = row_q;
    assign o_col = col_q;

endmodule

// File: rtl/dpc_seq.sv
// dpc_seq: frame sequencer for the DPC stage.
// Tracks pixel position and raises o_win_valid one cycle after each pixel
// that completes a 3x3 neighbourhood. It shadows the enable/threshold at
// frame start, delays the window strobe by the judge latency, and reports
// frame completion and line-length/framing errors.
// Stream: i_pix_valid marks one accepted pixel per cycle, and there is no
// backpressure. i_sof and i_eol are meaningful only while i_pix_valid is high.
//   clk, reset        - clock, asynchronous active-high reset
//   i_dpc_en          - correction enable, sampled on SOF
//   i_dpc_threshold   - deviation threshold, sampled on SOF
//   i_pix_valid       - pixel accepted this cycle
//   i_sof, i_eol      - first pixel of frame / last pixel of line
//   o_dpc_threshold   - shadowed threshold (8'hFF when correction is off)
//   o_win_valid       - 3x3 window complete, to the judge
//   o_out_valid       - o_win_valid delayed JUDGE_LAT cycles
//   o_row, o_col      - position of the last accepted pixel
//   o_busy            - a frame is in progress or draining
//   o_frame_done      - one-cycle pulse after the last judged pixel
//   o_err_len         - sticky length/framing error, cleared by a clean SOF
//   o_state           - current sequencer state, for debug
module dpc_seq import dpc_pkg::*; #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int CW        = 12,
    parameter int JUDGE_LAT = DPC_JUDGE_LAT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_dpc_en,
    input  logic [7:0]    i_dpc_threshold,
    input  logic          i_pix_valid,
    input  logic          i_sof,
    input  logic          i_eol,
    output logic [7:0]    o_dpc_threshold,
    output logic          o_win_valid,
    output logic          o_out_valid,
    output logic [CW-1:0] o_row,
    output logic [CW-1:0] o_col,
    output logic          o_busy,
    output logic          o_frame_done,
    output logic          o_err_len,
    output logic [1:0]    o_state
);

    localparam int             DW         = $clog2(JUDGE_LAT + 2);
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(JUDGE_LAT);
    localparam logic [CW-1:0]  LAST_ROW   = CW'(IMG_H - 1);

    dpc_state_t           state_q;
    logic [DW-1:0]        drain_q;
    logic                 win_q;
    logic                 done_q;
    logic                 err_q;
    logic [7:0]           thr_q;
    logic [JUDGE_LAT-1:0] pipe_q;

    logic          sof_acc, in_frame, drain_last, adv, stray, sof_err, err_set, cnt_clr;
    logic [CW-1:0] cur_row, cur_col;
    logic          line_end, len_err;

    always_comb begin
        sof_acc    = i_pix_valid & i_sof;
        in_frame   = (state_q == ST_FILL) || (state_q == ST_RUN);
        drain_last = (state_q == ST_DRAIN) && (drain_q == DRAIN_LAST);
        adv        = i_pix_valid & ~i_sof & in_frame;
        stray      = i_pix_valid & ~i_sof & ~in_frame;
        // An SOF is clean only from IDLE or in the last DRAIN cycle. An SOF that
        // also carries EOL is flagged.
        sof_err    = sof_acc & (i_eol | in_frame | ((state_q == ST_DRAIN) & ~drain_last));
        err_set    = sof_err | stray | (adv & len_err);
        cnt_clr    = (state_q == ST_IDLE) || drain_last;
    end

    dpc_pos_cnt #(
        .IMG_W (IMG_W),
        .CW    (CW)
    ) u_pos_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (cnt_clr),
        .i_sof      (sof_acc),
        .i_adv      (adv),
        .i_eol      (i_eol),
        .o_cur_row  (cur_row),
        .o_cur_col  (cur_col),
        .o_line_end (line_end),
        .o_len_err  (len_err),
        .o_row      (o_row),
        .o_col      (o_col)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            win_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            thr_q   <= DPC_BYPASS_THR;
        end else begin
            win_q  <= 1'b0;
            done_q <= 1'b0;

            if (sof_acc) begin
                thr_q <= i_dpc_en ? i_dpc_threshold : DPC_BYPASS_THR;
            end
            // A set takes priority over the clear, so a bad SOF leaves the flag up.
            if (err_set) begin
                err_q <= 1'b1;
            end else if (sof_acc) begin
                err_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (sof_acc) begin
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (sof_acc) begin
                        state_q <= ST_FILL;
                    end else if (adv && line_end && (cur_row == CW'(1))) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sof_acc) begin
                        state_q <= ST_FILL;
                    end else if (adv) begin
                        // Rows 0-1 are already buffered, so any col>=2 pixel closes a window.
                        win_q <= (cur_col >= CW'(2));
                        if (line_end && (cur_row == LAST_ROW)) begin
                            state_q <= ST_DRAIN;
                            drain_q <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_last) begin
                        done_q <= 1'b1;
                    end
                    if (sof_acc) begin
                        state_q <= ST_FILL;
                    end else if (drain_last) begin
                        state_q <= ST_IDLE;
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Mirrors the judge pipeline. It is never flushed by SOF, so windows already
    // issued for an aborted frame still emerge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= win_q;
            for (int i = 1; i < JUDGE_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign o_dpc_threshold = thr_q;
    assign o_win_valid     = win_q;
    assign o_out_valid     = pipe_q[JUDGE_LAT-1];
    assign o_busy          = (state_q != ST_IDLE);
    assign o_frame_done    = done_q;
    assign o_err_len       = err_q;
    assign o_state         = state_q;

endmodule

// File: tb/tb_dpc_seq.sv
// tb_dpc_seq: directed frames against dpc_seq (8x6 image, judge latency 3).
// A frame-level model predicts, for every clock edge, which outputs must
// pulse and what the position, threshold and error flag must be. A
// negedge compare process checks the outputs against it. Literal
// expectations after each scenario pin the model itself.
module tb_dpc_seq;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = 8;
    localparam int JL = 3;

    logic          clk;
    logic          reset;
    logic          i_dpc_en;
    logic [7:0]    i_dpc_threshold;
    logic          i_pix_valid;
    logic          i_sof;
    logic          i_eol;
    logic [7:0]    o_dpc_threshold;
    logic          o_win_valid;
    logic          o_out_valid;
    logic [CW-1:0] o_row;
    logic [CW-1:0] o_col;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_err_len;
    logic [1:0]    o_state;

    dpc_seq #(
        .IMG_W     (W),
        .IMG_H     (H),
        .CW        (CW),
        .JUDGE_LAT (JL)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_dpc_en        (i_dpc_en),
        .i_dpc_threshold (i_dpc_threshold),
        .i_pix_valid     (i_pix_valid),
        .i_sof           (i_sof),
        .i_eol           (i_eol),
        .o_dpc_threshold (o_dpc_threshold),
        .o_win_valid     (o_win_valid),
        .o_out_valid     (o_out_valid),
        .o_row           (o_row),
        .o_col           (o_col),
        .o_busy          (o_busy),
        .o_frame_done    (o_frame_done),
        .o_err_len       (o_err_len),
        .o_state         (o_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;
    int win_seen = 0;
    int done_seen = 0;
    int done_cyc = -1;
    int last_pix_cyc = -1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- frame-level model ----------------
    // phase: 0 no frame, 1 receiving lines, 2 waiting for the judge to empty
    int         m_phase;
    int         m_row, m_col;
    bit         m_wrap;
    logic [7:0] m_thr;
    bit         m_err;
    int         m_drain_end;
    bit         exp_win[int];
    bit         exp_out[int];
    bit         exp_done[int];

    task automatic model_reset();
        m_phase = 0; m_row = 0; m_col = 0; m_wrap = 1'b0;
        m_thr = 8'hFF; m_err = 1'b0; m_drain_end = -1;
        exp_win.delete(); exp_out.delete(); exp_done.delete();
    endtask

    // Called once per clock edge n with the inputs sampled at that edge.
    task automatic model_edge(input int n, input bit v, input bit sof, input bit eol,
                              input bit en, input logic [7:0] thr);
        bit legal;
        bit line_end;
        legal = (m_phase == 0) || (m_phase == 2 && n == m_drain_end);
        if (m_phase == 2 && n == m_drain_end) begin
            exp_done[n] = 1'b1;
            m_phase = 0; m_row = 0; m_col = 0;
        end
        if (v) begin
            if (sof) begin
                m_err = !legal || eol;
                m_thr = en ? thr : 8'hFF;
                m_phase = 1; m_row = 0; m_col = 0; m_wrap = 1'b0;
                m_drain_end = -1;
            end else if (m_phase == 1) begin
                if (m_wrap) begin
                    m_row++; m_col = 0;
                end else begin
                    m_col++;
                end
                line_end = eol || (m_col == W - 1);
                if (eol != (m_col == W - 1)) m_err = 1'b1;
                m_wrap = line_end;
                if (m_row >= 2 && m_col >= 2) begin
                    exp_win[n] = 1'b1;
                    exp_out[n + JL] = 1'b1;
                end
                if (line_end && m_row == H - 1) begin
                    m_phase = 2;
                    m_drain_end = n + JL + 1;
                end
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !reset) begin
                chk("win_valid",  o_win_valid,  exp_win.exists(cyc));
                chk("out_valid",  o_out_valid,  exp_out.exists(cyc));
                chk("frame_done", o_frame_done, exp_done.exists(cyc));
                chk("busy",       o_busy,       m_phase != 0);
                chk("err_len",    o_err_len,    m_err);
                chk("threshold",  o_dpc_threshold, m_thr);
                chk("row",        o_row,        m_row);
                chk("col",        o_col,        m_col);
                if (o_win_valid) win_seen++;
                if (o_frame_done) begin
                    done_seen++;
                    done_cyc = cyc;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit v, input bit sof, input bit eol,
                        input bit en, input logic [7:0] thr);
        i_pix_valid = v; i_sof = sof; i_eol = eol;
        i_dpc_en = en; i_dpc_threshold = thr;
        @(posedge clk);
        cyc++;
        model_edge(cyc, v, sof, eol, en, thr);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    // Sends one frame. short_row ends its line at col 5, noeol_row omits EOL,
    // the frame stops before (stop_row, stop_col), and pixels before linear
    // index start_idx are skipped (used to continue after a manual SOF).
    task automatic frame(input bit en, input logic [7:0] thr, input bit gaps,
                         input int start_idx, input int short_row, input int noeol_row,
                         input int stop_row, input int stop_col);
        for (int r = 0; r < H; r++) begin
            int len;
            len = (r == short_row) ? 6 : W;
            for (int c = 0; c < len; c++) begin
                bit sof;
                bit eol;
                if (r == stop_row && c == stop_col) return;
                if (r * W + c < start_idx) continue;
                sof = (r == 0 && c == 0);
                eol = (c == len - 1) && (r != noeol_row);
                if (gaps) idle($urandom_range(0, 2));
                if (sof) step(1'b1, 1'b1, eol, en, thr);
                else     step(1'b1, 1'b0, eol, 1'($urandom_range(0, 1)), 8'($urandom));
                last_pix_cyc = cyc;
            end
        end
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        i_pix_valid = 1'b0; i_sof = 1'b0; i_eol = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_win_valid",  o_win_valid, 0);
        chk("rst_out_valid",  o_out_valid, 0);
        chk("rst_busy",       o_busy, 0);
        chk("rst_frame_done", o_frame_done, 0);
        chk("rst_err_len",    o_err_len, 0);
        chk("rst_row",        o_row, 0);
        chk("rst_col",        o_col, 0);
        chk("rst_threshold",  o_dpc_threshold, 8'hFF);
        chk("rst_state",      o_state, 0);
        @(posedge clk);
        @(posedge clk);
        cyc += 2;
        #1;
        reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
    endtask

    // ---------------- timeout ----------------
    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish, failures so far %0d", n_fail);
        $fatal(1, "timeout");
    end

    // ---------------- scenarios ----------------
    initial begin
        int wb;
        int db;
        reset = 1'b0;
        i_dpc_en = 1'b0; i_dpc_threshold = 8'd0;
        i_pix_valid = 1'b0; i_sof = 1'b0; i_eol = 1'b0;
        model_reset();
        do_reset();
        idle(2);

        // Nominal frame, correction on.
        wb = win_seen; db = done_seen;
        frame(1'b1, 8'd40, 1'b0, 0, -1, -1, -1, -1);
        idle(JL + 3);
        chk("nom_windows", win_seen - wb, 24);
        chk("nom_done_count", done_seen - db, 1);
        chk("nom_done_delay", done_cyc - last_pix_cyc, JL + 1);
        chk("nom_threshold", o_dpc_threshold, 40);
        chk("nom_err", o_err_len, 0);

        // Correction off: bypass threshold.
        wb = win_seen;
        frame(1'b0, 8'd40, 1'b0, 0, -1, -1, -1, -1);
        idle(JL + 3);
        chk("byp_windows", win_seen - wb, 24);
        chk("byp_threshold", o_dpc_threshold, 8'hFF);

        // Random gaps, threshold wiggling mid-frame.
        wb = win_seen;
        frame(1'b1, 8'd99, 1'b1, 0, -1, -1, -1, -1);
        idle(JL + 3);
        chk("gap_windows", win_seen - wb, 24);
        chk("gap_threshold", o_dpc_threshold, 99);

        // Short line on row 3, missing EOL on row 4.
        wb = win_seen; db = done_seen;
        frame(1'b1, 8'd20, 1'b0, 0, 3, 4, -1, -1);
        idle(JL + 3);
        chk("len_windows", win_seen - wb, 22);
        chk("len_err", o_err_len, 1);
        chk("len_done_count", done_seen - db, 1);

        // Clean frame clears the flag.
        wb = win_seen;
        frame(1'b1, 8'd10, 1'b0, 0, -1, -1, -1, -1);
        idle(JL + 3);
        chk("clr_err", o_err_len, 0);
        chk("clr_windows", win_seen - wb, 24);

        // SOF at row 4 col 3 aborts and restarts.
        wb = win_seen; db = done_seen;
        frame(1'b1, 8'd30, 1'b0, 0, -1, -1, 4, 3);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'd77);
        chk("abort_err", o_err_len, 1);
        chk("abort_row", o_row, 0);
        chk("abort_col", o_col, 0);
        chk("abort_threshold", o_dpc_threshold, 77);
        chk("abort_busy", o_busy, 1);
        frame(1'b1, 8'd77, 1'b0, 1, -1, -1, -1, -1);
        idle(JL + 3);
        chk("abort_windows", win_seen - wb, 37);
        chk("abort_done_count", done_seen - db, 1);
        chk("abort_err_kept", o_err_len, 1);

        // Back-to-back: next SOF lands in the last drain cycle.
        wb = win_seen; db = done_seen;
        frame(1'b1, 8'd50, 1'b0, 0, -1, -1, -1, -1);
        idle(JL);
        frame(1'b1, 8'd60, 1'b0, 0, -1, -1, -1, -1);
        idle(JL + 3);
        chk("b2b_done_count", done_seen - db, 2);
        chk("b2b_windows", win_seen - wb, 48);
        chk("b2b_err", o_err_len, 0);
        chk("b2b_threshold", o_dpc_threshold, 60);

        // Stray pixel with no frame open.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("stray_err", o_err_len, 1);
        chk("stray_busy", o_busy, 0);
        idle(2);

        // Reset in the middle of RUN, then a normal frame.
        frame(1'b1, 8'd45, 1'b0, 0, -1, -1, 3, 4);
        do_reset();
        idle(2);
        wb = win_seen; db = done_seen;
        frame(1'b1, 8'd45, 1'b0, 0, -1, -1, -1, -1);
        idle(JL + 3);
        chk("post_rst_windows", win_seen - wb, 24);
        chk("post_rst_done", done_seen - db, 1);
        chk("post_rst_err", o_err_len, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
